// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor switch decoder with dead-time
// gate control: leg states, sector numbering, zero-vector policies.
package ac_motor_pkg;

  typedef logic [1:0] leg_state_t;

  localparam leg_state_t LEG_OFF  = 2'd0;
  localparam leg_state_t LEG_DEAD = 2'd1;
  localparam leg_state_t LEG_ON_H = 2'd2;
  localparam leg_state_t LEG_ON_L = 2'd3;

  localparam logic [2:0] SEC_0 = 3'd0;
  localparam logic [2:0] SEC_1 = 3'd1;
  localparam logic [2:0] SEC_2 = 3'd2;
  localparam logic [2:0] SEC_3 = 3'd3;
  localparam logic [2:0] SEC_4 = 3'd4;
  localparam logic [2:0] SEC_5 = 3'd5;

  localparam int ZM_V0  = 0;
  localparam int ZM_V7  = 1;
  localparam int ZM_ALT = 2;

  localparam logic [2:0] VEC_V0 = 3'b000;
  localparam logic [2:0] VEC_V7 = 3'b111;

  // Lower active vector of a sector, bit order (S_3,S_2,S_1).
  function automatic logic [2:0] sector_vec(input logic [2:0] sector);
    logic [2:0] v;
    case (sector)
      SEC_0:   v = 3'b001;
      SEC_1:   v = 3'b011;
      SEC_2:   v = 3'b010;
      SEC_3:   v = 3'b110;
      SEC_4:   v = 3'b100;
      SEC_5:   v = 3'b101;
      default: v = VEC_V0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ac_motor_leg_deadtime.sv
// One inverter leg: complementary gate pair with a dead-time counter between
// every change of conducting side, and immediate shutdown on fault/disable.
module ac_motor_leg_deadtime
  import ac_motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 8,
  parameter int DT_W        = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic fault_i,
  input  logic target_i,
  output logic g_h_o,
  output logic g_l_o
);

  localparam logic [DT_W-1:0] DEAD_LOAD = DT_W'(DEAD_CYCLES);
  localparam logic [DT_W-1:0] CNT_LAST  = DT_W'(1);

  leg_state_t      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_i || !enable_i) begin
      state_d = LEG_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LEG_OFF: begin
          state_d = LEG_DEAD;
          cnt_d   = DEAD_LOAD;
        end
        LEG_DEAD: begin
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) state_d = target_i ? LEG_ON_H : LEG_ON_L;
        end
        LEG_ON_H: if (!target_i) begin
          state_d = LEG_DEAD;
          cnt_d   = DEAD_LOAD;
        end
        LEG_ON_L: if (target_i) begin
          state_d = LEG_DEAD;
          cnt_d   = DEAD_LOAD;
        end
        default: begin
          state_d = LEG_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_ni) begin
      state_q <= LEG_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gates decode from a single state register, so both can never be on together.
  assign g_h_o = (state_q == LEG_ON_H);
  assign g_l_o = (state_q == LEG_ON_L);

endmodule

// File: rtl/ac_motor_switch_deadtime.sv
// SVM sector/select decoder driving N_PHASE dead-time protected gate legs,
// with zero-vector policy and a sticky invalid-input flag.
module ac_motor_switch_deadtime
  import ac_motor_pkg::*;
#(
  parameter int N_PHASE     = 3,
  parameter int DEAD_CYCLES = 8,
  parameter int DT_W        = 8,
  parameter int ZERO_MODE   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               fault_i,
  input  logic [2:0]         sector_i,
  input  logic               u_0_i,
  input  logic               u_low_i,
  input  logic               u_high_i,
  output logic [N_PHASE-1:0] g_h_o,
  output logic [N_PHASE-1:0] g_l_o,
  output logic [2:0]         vec_o,
  output logic               in_err_o
);

  if (N_PHASE != 3) begin : g_bad_phase
    $error("ac_motor_switch_deadtime: only N_PHASE=3 is decoded");
  end
  if (DEAD_CYCLES < 1 || DEAD_CYCLES > (2**DT_W) - 1) begin : g_bad_dead
    $error("ac_motor_switch_deadtime: DEAD_CYCLES out of range for DT_W");
  end

  logic [2:0] vec_q, vec_d;
  logic       alt_q, alt_d;
  logic       err_q, err_d;

  logic [1:0] sel_cnt;
  logic       sel_bad;
  logic       vec_active;
  logic [2:0] sector_up;

  assign sel_cnt    = 2'(u_0_i) + 2'(u_low_i) + 2'(u_high_i);
  assign sel_bad    = (sel_cnt > 2'd1) || ((sector_i > SEC_5) && (u_low_i || u_high_i));
  assign vec_active = (vec_q != VEC_V0) && (vec_q != VEC_V7);
  // The upper vector of sector k is the lower vector of sector k+1.
  assign sector_up  = (sector_i == SEC_5) ? SEC_0 : sector_i + 3'd1;

  always_comb begin
    vec_d = vec_q;
    alt_d = alt_q;
    err_d = err_q;
    if (sel_bad) begin
      err_d = 1'b1;
    end else if (u_0_i) begin
      case (ZERO_MODE)
        ZM_V0:   vec_d = VEC_V0;
        ZM_V7:   vec_d = VEC_V7;
        default: if (vec_active) begin
          vec_d = alt_q ? VEC_V7 : VEC_V0;
          alt_d = ~alt_q;
        end
      endcase
    end else if (u_low_i) begin
      vec_d = sector_vec(sector_i);
    end else if (u_high_i) begin
      vec_d = sector_vec(sector_up);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vec_q <= VEC_V0;
      alt_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      alt_q <= alt_d;
      err_q <= err_d;
    end
  end

  assign vec_o    = vec_q;
  assign in_err_o = err_q;

  for (genvar i = 0; i < N_PHASE; i++) begin : g_leg
    ac_motor_leg_deadtime #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .DT_W       (DT_W)
    ) u_leg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .enable_i(enable_i),
      .fault_i (fault_i),
      .target_i(vec_q[i % 3]),
      .g_h_o   (g_h_o[i]),
      .g_l_o   (g_l_o[i])
    );
  end

endmodule

// File: tb/tb_ac_motor_switch_deadtime.sv
// Self-checking bench: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model of vector and gate timing.
module tb_ac_motor_switch_deadtime;

  localparam int DEAD = 8;

  logic       clk = 1'b0;
  logic       rst_n, enable, fault, u_0, u_low, u_high;
  logic [2:0] sector;
  logic [2:0] g_h, g_l, vec;
  logic       in_err;

  int checks = 0;
  int errors = 0;

  ac_motor_switch_deadtime #(
    .N_PHASE    (3),
    .DEAD_CYCLES(DEAD),
    .DT_W       (8),
    .ZERO_MODE  (2)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .enable_i(enable),
    .fault_i (fault),
    .sector_i(sector),
    .u_0_i   (u_0),
    .u_low_i (u_low),
    .u_high_i(u_high),
    .g_h_o   (g_h),
    .g_l_o   (g_l),
    .vec_o   (vec),
    .in_err_o(in_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: each leg is either disabled (-1), waiting out N more
  // dead cycles (N>0), or conducting on m_side (0).
  logic [2:0] tbl [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [2:0] m_vec = 3'b000;
  logic       m_alt = 1'b0;
  logic       m_err = 1'b0;
  int         m_dead [3] = '{-1, -1, -1};
  logic       m_side [3] = '{1'b0, 1'b0, 1'b0};

  task automatic model_step();
    int nsel;
    int sec;
    nsel = int'(u_0) + int'(u_low) + int'(u_high);
    sec  = int'(sector);
    if (!rst_n) begin
      m_vec = 3'b000;
      m_alt = 1'b0;
      m_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_dead[i] = -1;
        m_side[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fault || !enable) m_dead[i] = -1;
        else if (m_dead[i] < 0) m_dead[i] = DEAD;
        else if (m_dead[i] == 1) begin
          m_dead[i] = 0;
          m_side[i] = m_vec[i];
        end else if (m_dead[i] > 1) m_dead[i] = m_dead[i] - 1;
        else if (m_side[i] != m_vec[i]) m_dead[i] = DEAD;
      end
      if (nsel > 1 || (sec > 5 && (u_low || u_high))) m_err = 1'b1;
      else if (u_0) begin
        if (m_vec != 3'b000 && m_vec != 3'b111) begin
          m_vec = m_alt ? 3'b111 : 3'b000;
          m_alt = !m_alt;
        end
      end else if (u_low) m_vec = tbl[sec];
      else if (u_high) m_vec = tbl[(sec + 1) % 6];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process plus per-leg dead-gap and overlap monitors.
  int   low_run [3] = '{0, 0, 0};
  logic ph [3] = '{1'b0, 1'b0, 1'b0};
  logic pl [3] = '{1'b0, 1'b0, 1'b0};

  initial forever begin
    logic [2:0] eh, el;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      eh[i] = (m_dead[i] == 0) && m_side[i];
      el[i] = (m_dead[i] == 0) && !m_side[i];
    end
    check("model_vec", vec, m_vec);
    check("model_err", in_err, m_err);
    check("model_gh", g_h, eh);
    check("model_gl", g_l, el);
    check("overlap", g_h & g_l, 0);
    for (int i = 0; i < 3; i++) begin
      if ((g_h[i] === 1'b1 && !ph[i]) || (g_l[i] === 1'b1 && !pl[i]))
        check("dead_gap", low_run[i] >= DEAD, 1);
      if (g_h[i] === 1'b0 && g_l[i] === 1'b0) low_run[i]++;
      else low_run[i] = 0;
      ph[i] = (g_h[i] === 1'b1);
      pl[i] = (g_l[i] === 1'b1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sel(input logic [2:0] s, input logic z, input logic lo, input logic hi);
    sector = s;
    u_0    = z;
    u_low  = lo;
    u_high = hi;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    fault  = 1'b0;
    sel(3'd0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    check("rst_gh", g_h, 0);
    check("rst_gl", g_l, 0);
    check("rst_vec", vec, 0);
    check("rst_err", in_err, 0);

    // Start-up: legs wait DEAD cycles from reset release, then conduct.
    rst_n = 1'b1;
    sel(3'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check("start_vec", vec, 3'b001);
    check("start_gh0", g_h, 0);
    cyc(7);
    check("start_gh8", g_h | g_l, 0);
    cyc(1);
    check("start_gh9", g_h, 3'b001);
    check("start_gl9", g_l, 3'b110);

    // Lower to upper vector of sector 0: only phase 2 swaps.
    sel(3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1);
    check("sw_vec", vec, 3'b011);
    check("sw_gl1", g_l, 3'b110);
    cyc(1);
    check("sw_gl2", g_l, 3'b100);
    check("sw_gh2", g_h, 3'b001);
    cyc(7);
    check("sw_gh9", g_h, 3'b001);
    cyc(1);
    check("sw_gh10", g_h, 3'b011);
    check("sw_gl10", g_l, 3'b100);

    // Zero-vector alternation and hold.
    sel(3'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    check("zero_first", vec, 3'b000);
    cyc(5);
    check("zero_hold", vec, 3'b000);
    sel(3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1);
    check("zero_act", vec, 3'b011);
    sel(3'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    check("zero_second", vec, 3'b111);

    // Fault pulse drops all gates, then re-entry waits a full dead time.
    sel(3'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    sel(3'd0, 1'b0, 1'b0, 1'b0);
    cyc(20);
    check("pre_fault_gh", g_h, 3'b001);
    fault = 1'b1;
    cyc(1);
    check("fault_gh", g_h, 0);
    check("fault_gl", g_l, 0);
    fault = 1'b0;
    cyc(8);
    check("refault_off", g_h | g_l, 0);
    cyc(1);
    check("refault_gh", g_h, 3'b001);
    check("refault_gl", g_l, 3'b110);

    // Invalid inputs: VEC holds, error is sticky until reset.
    sel(3'd6, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check("bad_sec_vec", vec, 3'b001);
    check("bad_sec_err", in_err, 1);
    sel(3'd0, 1'b0, 1'b0, 1'b0);
    cyc(3);
    check("err_sticky", in_err, 1);
    rst_n = 1'b0;
    cyc(1);
    check("err_clear", in_err, 0);
    check("reset_mid_on", g_h | g_l, 0);
    rst_n = 1'b1;
    sel(3'd2, 1'b0, 1'b1, 1'b1);
    cyc(1);
    check("multi_vec", vec, 3'b000);
    check("multi_err", in_err, 1);
    sel(3'd2, 1'b0, 1'b1, 1'b0);
    cyc(1);
    check("sec2_low", vec, 3'b010);
    sel(3'd5, 1'b0, 1'b0, 1'b1);
    cyc(1);
    check("sec5_high", vec, 3'b001);

    // Randomized run checked by the model every cycle.
    for (int n = 0; n < 20000; n++) begin
      rst_n  = ($urandom_range(0, 999) != 0);
      enable = ($urandom_range(0, 99) != 0);
      fault  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) begin
        int r;
        r = int'($urandom_range(0, 15));
        sector = 3'($urandom_range(0, 5));
        if ($urandom_range(0, 9) == 0) sector = 3'($urandom_range(6, 7));
        if (r < 4) sel(sector, 1'b1, 1'b0, 1'b0);
        else if (r < 9) sel(sector, 1'b0, 1'b1, 1'b0);
        else if (r < 14) sel(sector, 1'b0, 1'b0, 1'b1);
        else if (r == 14) sel(sector, 1'b0, 1'b0, 1'b0);
        else sel(sector, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
